// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA line-fetch arbiter.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int V_VISIBLE_DEF = 480;
    localparam int BURST_LEN_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_CMD,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/vga_line_fetch_arbiter_if.sv
// Pixel-memory command/read-data port shared by the fetch and write paths.
interface vga_line_fetch_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/vga_line_fetch_arbiter_fetch_addr_gen.sv
// Line base, burst index and beat counters for the line prefetcher.
module vga_fetch_addr_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int ADDR_W    = 19,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [10:0]       line_num,
    input  logic              beat_inc,
    input  logic              burst_inc,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [9:0]        lb_addr,
    output logic              beat_last,
    output logic              line_last
);
    localparam int BEAT_W  = $clog2(BURST_LEN);
    localparam int N_BURST = H_VISIBLE / BURST_LEN;
    localparam int BIDX_W  = (N_BURST > 1) ? $clog2(N_BURST) : 1;

    logic [ADDR_W-1:0] base;
    logic [BIDX_W-1:0] burst_idx;
    logic [BEAT_W-1:0] beat;

    // beat keeps counting across a reload so a drained burst still ends on time
    always_ff @(posedge clk) begin
        if (reset) begin
            base      <= '0;
            burst_idx <= '0;
            beat      <= '0;
        end else begin
            if (beat_inc)
                beat <= beat + BEAT_W'(1);
            if (load) begin
                base      <= ADDR_W'(line_num) * ADDR_W'(H_VISIBLE);
                burst_idx <= '0;
            end else if (burst_inc) begin
                burst_idx <= burst_idx + BIDX_W'(1);
            end
        end
    end

    assign rd_addr   = base + ADDR_W'({burst_idx, {BEAT_W{1'b0}}});
    assign lb_addr   = 10'({burst_idx, beat});
    assign beat_last = &beat;
    assign line_last = (burst_idx == BIDX_W'(N_BURST - 1));

endmodule

// File: rtl/vga_line_fetch_arbiter.sv
// Line prefetch / writer arbiter on one pixel-memory port.
// Define VGA_ARB_FAIR_EN to grant one pending write between bursts of a line.
module vga_line_fetch_arbiter
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [10:0]       line_num,
    output logic              fetch_done,
    output logic              underrun,
    input  logic              clr_underrun,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic [DATA_W-1:0] lb_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    vga_line_fetch_arbiter_if.master mem
);
`ifdef VGA_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    arb_state_t        state;
    logic              fetch_pend;
    logic              start_ok;
    logic              beat_in;
    logic              burst_end;
    logic              beat_last;
    logic              line_last;
    logic [ADDR_W-1:0] rd_addr;

    assign start_ok  = line_start && (line_num < 11'(V_VISIBLE));
    assign beat_in   = mem.mem_rvalid && ((state == RD_DATA) || (state == DRAIN));
    assign burst_end = beat_in && beat_last;

    vga_fetch_addr_gen #(
        .H_VISIBLE (H_VISIBLE),
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_addr (
        .clk       (vga_clk),
        .reset     (reset),
        .load      (start_ok),
        .line_num  (line_num),
        .beat_inc  (beat_in),
        .burst_inc ((state == RD_DATA) && burst_end && !line_last),
        .rd_addr   (rd_addr),
        .lb_addr   (lb_addr),
        .beat_last (beat_last),
        .line_last (line_last)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pend <= 1'b0;
            fetch_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            unique case (state)
                IDLE:
                    if (fetch_pend || start_ok) state <= RD_CMD;
                    else if (wr_req)            state <= WR_CMD;
                RD_CMD:
                    // an ack racing a retarget returns stale beats; drain them
                    if (mem.mem_ack) state <= start_ok ? DRAIN : RD_DATA;
                RD_DATA:
                    if (burst_end) begin
                        if (line_last) begin
                            fetch_done <= 1'b1;
                            fetch_pend <= 1'b0;
                            state      <= IDLE;
                        end else if (FAIR && wr_req) begin
                            state <= WR_CMD;
                        end else begin
                            state <= RD_CMD;
                        end
                    end else if (start_ok) begin
                        state <= DRAIN;
                    end
                WR_CMD:
                    if (mem.mem_ack) state <= IDLE;
                DRAIN:
                    if (burst_end) state <= RD_CMD;
                default:
                    state <= IDLE;
            endcase
            if (start_ok)
                fetch_pend <= 1'b1;
            if (clr_underrun)
                underrun <= 1'b0;
            if (start_ok && fetch_pend)
                underrun <= 1'b1;
        end
    end

    assign mem.mem_req   = (state == RD_CMD) || (state == WR_CMD);
    assign mem.mem_we    = (state == WR_CMD);
    assign mem.mem_addr  = mem.mem_we ? wr_addr : rd_addr;
    assign mem.mem_wdata = mem.mem_we ? wr_data : '0;
    assign wr_ack        = mem.mem_we && mem.mem_ack;
    assign lb_we         = (state == RD_DATA) && mem.mem_rvalid;
    assign lb_data       = lb_we ? mem.mem_rdata : '0;

endmodule
